// File: rtl/mem_wb_writeback_pkg.sv
// Shared MEM/WB definitions: datapath widths, writeback FSM encoding and the
// MEM/WB pipeline-register bundle.
package mem_wb_writeback_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wbState_t;

    // "reg" is a keyword, so the destination field is named dest
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     load;
    } memWb_t;

endpackage

// File: rtl/mem_wb_writeback_memwb_reg.sv
// MEM/WB pipeline register: valid is rewritten every cycle, the instruction
// fields and the load-data field load independently and otherwise hold.
module memwb_reg
    import mem_wb_writeback_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   ldFields,
    input  logic   ldLoad,
    input  logic   validIn,
    input  memWb_t d,
    output memWb_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q.valid <= validIn;
            if (ldFields) begin
                q.reg_write  <= d.reg_write;
                q.mem_to_reg <= d.mem_to_reg;
                q.dest       <= d.dest;
                q.alu        <= d.alu;
            end
            if (ldLoad) begin
                q.load <= d.load;
            end
        end
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB stage and writeback unit: captures EX/MEM results, waits for late
// load data, and drives the register-file write port.
module mem_wb_writeback #(
    parameter int DATA_W     = mem_wb_writeback_pkg::DATA_W,
    parameter int REG_ADDR_W = mem_wb_writeback_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hit,
    input  logic                  ex_valid,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_rdata_valid,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0]     writeData,
    output logic                  regWriteSignal,
    output logic                  mem_busy,
    output logic [CNT_W-1:0]      retired_count
);

    import mem_wb_writeback_pkg::*;

    wbState_t state;
    wbState_t nextState;
    logic     ldFields;
    logic     ldLoad;
    logic     validIn;
    memWb_t   exBundle;
    memWb_t   wb;

    always_comb begin
        exBundle            = '0;
        exBundle.valid      = ex_valid;
        exBundle.reg_write  = ex_reg_write;
        exBundle.mem_to_reg = ex_mem_to_reg;
        exBundle.dest       = ex_write_reg;
        exBundle.alu        = ex_alu_result;
        exBundle.load       = dmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A load without same-cycle data parks its fields in MEM/WB with valid
    // low; only the load-data field is filled in once the response arrives.
    always_comb begin
        nextState = state;
        ldFields  = 1'b0;
        ldLoad    = 1'b0;
        validIn   = 1'b0;
        unique case (state)
            IDLE: begin
                if (hit && ex_valid) begin
                    ldFields = 1'b1;
                    if (!ex_mem_read) begin
                        validIn = 1'b1;
                    end else if (dmem_rdata_valid) begin
                        ldLoad  = 1'b1;
                        validIn = 1'b1;
                    end else begin
                        nextState = WAIT_LOAD;
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_rdata_valid) begin
                    ldLoad    = 1'b1;
                    validIn   = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    memwb_reg uMemWbReg (
        .clk      (clk),
        .rst      (rst),
        .ldFields (ldFields),
        .ldLoad   (ldLoad),
        .validIn  (validIn),
        .d        (exBundle),
        .q        (wb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_count <= '0;
        end else if (wb.valid) begin
            retired_count <= retired_count + 1'b1;
        end
    end

    assign mem_busy       = (state == WAIT_LOAD);
    assign writeReg       = wb.dest;
    assign writeData      = wb.mem_to_reg ? wb.load : wb.alu;
    assign regWriteSignal = wb.valid & wb.reg_write & (wb.dest != '0);

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed-vector bench for mem_wb_writeback with hand-computed expectations.
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        hit;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        ex_mem_read;
    logic [4:0]  ex_write_reg;
    logic [31:0] ex_alu_result;
    logic [31:0] dmem_rdata;
    logic        dmem_rdata_valid;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        regWriteSignal;
    logic        mem_busy;
    logic [31:0] retired_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_wb_writeback #(
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .CNT_W      (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .hit              (hit),
        .ex_valid         (ex_valid),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_to_reg    (ex_mem_to_reg),
        .ex_mem_read      (ex_mem_read),
        .ex_write_reg     (ex_write_reg),
        .ex_alu_result    (ex_alu_result),
        .dmem_rdata       (dmem_rdata),
        .dmem_rdata_valid (dmem_rdata_valid),
        .writeReg         (writeReg),
        .writeData        (writeData),
        .regWriteSignal   (regWriteSignal),
        .mem_busy         (mem_busy),
        .retired_count    (retired_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setEx(input logic v, input logic rw, input logic mtr, input logic mr,
                         input logic [4:0] rd, input logic [31:0] alu);
        ex_valid      = v;
        ex_reg_write  = rw;
        ex_mem_to_reg = mtr;
        ex_mem_read   = mr;
        ex_write_reg  = rd;
        ex_alu_result = alu;
    endtask

    initial begin
        rst = 1'b1;
        hit = 1'b0;
        setEx(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        dmem_rdata       = 32'h0;
        dmem_rdata_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_writeReg", 32'(writeReg), 32'd0);
        check("rst_writeData", writeData, 32'd0);
        check("rst_regWrite", 32'(regWriteSignal), 32'd0);
        check("rst_busy", 32'(mem_busy), 32'd0);
        check("rst_retired", retired_count, 32'd0);

        // R-type to $8
        hit = 1'b1;
        setEx(1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 32'h0000_0005);
        step();
        ex_valid = 1'b0;
        check("rtype_writeReg", 32'(writeReg), 32'd8);
        check("rtype_writeData", writeData, 32'd5);
        check("rtype_regWrite", 32'(regWriteSignal), 32'd1);
        check("rtype_retired_pre", retired_count, 32'd0);
        step();
        check("rtype_once", 32'(regWriteSignal), 32'd0);
        check("rtype_retired", retired_count, 32'd1);

        // Load with data in the same cycle
        setEx(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0100);
        dmem_rdata       = 32'hDEAD_BEEF;
        dmem_rdata_valid = 1'b1;
        #1;
        check("ld0_busy_req", 32'(mem_busy), 32'd0);
        step();
        ex_valid         = 1'b0;
        dmem_rdata_valid = 1'b0;
        check("ld0_busy", 32'(mem_busy), 32'd0);
        check("ld0_writeReg", 32'(writeReg), 32'd9);
        check("ld0_writeData", writeData, 32'hDEAD_BEEF);
        check("ld0_regWrite", 32'(regWriteSignal), 32'd1);
        step();
        check("ld0_retired", retired_count, 32'd2);

        // Load with the response three cycles late
        setEx(1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_0200);
        dmem_rdata = 32'h0;
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ldw_busy", 32'(mem_busy), 32'd1);
            check("ldw_regWrite", 32'(regWriteSignal), 32'd0);
            step();
        end
        dmem_rdata       = 32'h0000_1234;
        dmem_rdata_valid = 1'b1;
        #1;
        check("ldw_busy_resp", 32'(mem_busy), 32'd1);
        check("ldw_regWrite_resp", 32'(regWriteSignal), 32'd0);
        step();
        dmem_rdata_valid = 1'b0;
        check("ldw_busy_done", 32'(mem_busy), 32'd0);
        check("ldw_regWrite", 32'(regWriteSignal), 32'd1);
        check("ldw_writeReg", 32'(writeReg), 32'd10);
        check("ldw_writeData", writeData, 32'h0000_1234);
        check("ldw_retired_pre", retired_count, 32'd2);
        step();
        check("ldw_once", 32'(regWriteSignal), 32'd0);
        check("ldw_retired", retired_count, 32'd3);

        // Write to $zero is suppressed but still retires
        setEx(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF);
        step();
        ex_valid = 1'b0;
        check("zero_regWrite", 32'(regWriteSignal), 32'd0);
        check("zero_writeData", writeData, 32'hFFFF_FFFF);
        step();
        check("zero_retired", retired_count, 32'd4);

        // Four frozen cycles, then advance: exactly one writeback
        hit = 1'b0;
        setEx(1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0077);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_regWrite", 32'(regWriteSignal), 32'd0);
        end
        check("stall_retired_hold", retired_count, 32'd4);
        hit = 1'b1;
        step();
        ex_valid = 1'b0;
        check("stall_regWrite_go", 32'(regWriteSignal), 32'd1);
        check("stall_writeReg", 32'(writeReg), 32'd12);
        check("stall_writeData", writeData, 32'h0000_0077);
        step();
        check("stall_once", 32'(regWriteSignal), 32'd0);
        check("stall_retired", retired_count, 32'd5);

        // Reset while waiting on a load, colliding with a response
        setEx(1'b1, 1'b1, 1'b1, 1'b1, 5'd13, 32'h0000_0300);
        step();
        ex_valid = 1'b0;
        check("rstld_busy", 32'(mem_busy), 32'd1);
        rst              = 1'b1;
        dmem_rdata       = 32'h0000_5555;
        dmem_rdata_valid = 1'b1;
        step();
        rst              = 1'b0;
        dmem_rdata_valid = 1'b0;
        check("rstld_busy_after", 32'(mem_busy), 32'd0);
        check("rstld_retired", retired_count, 32'd0);
        dmem_rdata_valid = 1'b1;
        step();
        dmem_rdata_valid = 1'b0;
        check("rstld_late_regWrite", 32'(regWriteSignal), 32'd0);
        check("rstld_late_busy", 32'(mem_busy), 32'd0);
        step();
        check("rstld_late_retired", retired_count, 32'd0);
        check("rstld_late_regWrite2", 32'(regWriteSignal), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
